// File: rtl/conv_stream_feeder_pkg.sv
// Shared definitions for the convolution feeder, engine and PE.
package conv_pkg;

   localparam int unsigned DEF_DATA_W     = 8;
   localparam int unsigned DEF_FRAME_LEN  = 3;
   localparam int unsigned DEF_TAPS       = 3;
   localparam int unsigned DEF_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } feed_state_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/conv_stream_feeder_if.sv
// Sample stream handshake into the feeder.
interface conv_stream_feeder_if
   import conv_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W
);
   logic              s_valid;
   logic [DATA_W-1:0] s_data;
   logic              s_ready;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/conv_sample_fifo.sv
// Small synchronous sample FIFO with registered read data.
module conv_sample_fifo #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 4,
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic [CW-1:0]     count,
   output logic              full,
   output logic              empty
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     count_q, count_d;
   logic              push_ok, pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign count   = count_q;

   // Occupancy: simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointers and occupancy; pointers wrap naturally (power-of-two depth).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   // Storage array, no reset needed.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din;
   end

   // Registered read port, updated only on a pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      dout <= '0;
      else if (pop_ok) dout <= mem_q[rd_ptr_q];
   end

endmodule

// File: rtl/conv_stream_feeder.sv
// Buffers input samples and releases them as uninterrupted frames followed
// by zero flush cycles for the systolic convolution engine.
module conv_stream_feeder
   import conv_pkg::*;
#(
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned FRAME_LEN  = DEF_FRAME_LEN,
   parameter int unsigned TAPS       = DEF_TAPS,
   parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   conv_stream_feeder_if.slave  s_if,
   output logic [DATA_W-1:0]    x_out,
   output logic                 x_valid,
   output logic                 frame_start,
   output logic                 frame_done,
   output logic                 busy,
   output logic [15:0]          frame_cnt
);

   localparam int unsigned CntW      = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SlotW     = max_u(1, $clog2(max_u(FRAME_LEN, TAPS)));
   localparam int unsigned FlushLast = (TAPS > 1) ? TAPS - 2 : 0;

   feed_state_e       state_q, state_d;
   logic [SlotW-1:0]  slot_q, slot_d;
   logic [15:0]       frame_cnt_q;
   logic              pop_req;
   logic [DATA_W-1:0] fifo_dout;
   logic [CntW-1:0]   fifo_count;
   logic              fifo_full, fifo_empty;

   conv_sample_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (s_if.s_valid),
      .pop   (pop_req & ~fifo_empty),
      .din   (s_if.s_data),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign s_if.s_ready = ~fifo_full;

   // Next state; the pop is issued one cycle ahead so the registered FIFO
   // read lands on x_out in the matching FEED cycle.
   always_comb begin
      state_d = state_q;
      pop_req = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (fifo_count >= CntW'(FRAME_LEN)) begin
               state_d = FEED;
               pop_req = 1'b1;
            end
         end
         FEED: begin
            if (slot_q == SlotW'(FRAME_LEN - 1)) begin
               if (TAPS > 1) state_d = FLUSH;
               else          state_d = DONE;
            end else begin
               pop_req = 1'b1;
            end
         end
         FLUSH: begin
            if (slot_q == SlotW'(FlushLast)) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Slot counter restarts on every state entry.
   always_comb begin
      slot_d = slot_q + SlotW'(1);
      if (state_d != state_q) slot_d = '0;
   end

   // State, slot and completed-frame counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         slot_q      <= '0;
         frame_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         if (state_d == DONE) frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end

   // Outputs decoded from registered state only.
   always_comb begin
      x_valid     = (state_q == FEED) || (state_q == FLUSH);
      x_out       = (state_q == FEED) ? fifo_dout : '0;
      frame_start = (state_q == FEED) && (slot_q == '0);
      frame_done  = (state_q == DONE);
      busy        = (state_q != IDLE);
      frame_cnt   = frame_cnt_q;
   end

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Scoreboard bench for conv_stream_feeder.
module tb_conv_stream_feeder;
   import conv_pkg::*;

   localparam int unsigned DW    = DEF_DATA_W;
   localparam int unsigned FL    = DEF_FRAME_LEN;
   localparam int unsigned NT    = DEF_TAPS;
   localparam int unsigned FD    = DEF_FIFO_DEPTH;
   localparam int unsigned SLOTS = FL + NT - 1;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;
   logic [DW-1:0] x_out;
   logic          x_valid, frame_start, frame_done, busy;
   logic [15:0]   frame_cnt;

   conv_stream_feeder_if #(.DATA_W(DW)) s_if ();

   conv_stream_feeder #(
      .DATA_W     (DW),
      .FRAME_LEN  (FL),
      .TAPS       (NT),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_if        (s_if),
      .x_out       (x_out),
      .x_valid     (x_valid),
      .frame_start (frame_start),
      .frame_done  (frame_done),
      .busy        (busy),
      .frame_cnt   (frame_cnt)
   );

   always #5 clk = ~clk;

   int            vectors     = 0;
   int            miscompares = 0;
   logic [DW-1:0] pend_q[$];
   logic [DW-1:0] exp_q[$];
   longint        start_q[$];
   int            pos      = 0;
   bit            prev_end = 1'b0;
   int            done_cnt = 0;
   longint        cyc      = 0;
   bit            bp_seen  = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: every FRAME_LEN accepted samples form one frame of the
   // samples in order followed by TAPS-1 zeros.
   task automatic accept(input logic [DW-1:0] v);
      pend_q.push_back(v);
      if (pend_q.size() == FL) begin
         foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
         for (int i = 0; i < NT - 1; i++) exp_q.push_back('0);
         pend_q.delete();
      end
   endtask

   // Monitor: compares every DUT output cycle against the scoreboard.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         pos      = 0;
         prev_end = 1'b0;
         done_cnt = 0;
      end else begin
         if (!s_if.s_ready) bp_seen = 1'b1;
         check("frame_done_timing", frame_done, prev_end);
         if (frame_done) begin
            done_cnt++;
            check("frame_cnt", frame_cnt, 64'(16'(done_cnt)));
         end
         prev_end = 1'b0;
         if (x_valid) begin
            check("busy_in_frame", busy, 1);
            check("frame_start", frame_start, pos == 0);
            if (pos == 0) start_q.push_back(cyc);
            if (exp_q.size() == 0) check("x_valid_unexpected", x_valid, 0);
            else                   check("x_out", x_out, exp_q.pop_front());
            pos++;
            if (pos == SLOTS) begin
               pos      = 0;
               prev_end = 1'b1;
            end
         end else begin
            if (pos != 0) check("x_valid_gap", x_valid, 1);
            check("frame_start_idle", frame_start, 0);
            check("x_out_idle", x_out, 0);
         end
      end
   end

   task automatic push(input logic [DW-1:0] v);
      bit ok = 1'b0;
      bit rdy;
      s_if.s_valid = 1'b1;
      s_if.s_data  = v;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         rdy = s_if.s_ready;
         @(posedge clk);
         #1;
         if (rdy) ok = 1'b1;
      end
      s_if.s_valid = 1'b0;
      if (ok) accept(v);
      else    check("push_timeout_s_ready", s_if.s_ready, 1);
   endtask

   task automatic wait_drain(input int bound);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < bound) begin
         @(negedge clk);
         n++;
      end
      check("drain_busy", busy, 0);
      check("drain_pending_slots", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      s_if.s_valid = 1'b0;
      s_if.s_data  = '0;
      #2 rst_n = 1'b0;
      #20;
      check("rst_x_valid", x_valid, 0);
      check("rst_x_out", x_out, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_start", frame_start, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_s_ready", s_if.s_ready, 1);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic frame 5,7,9.
      push(8'd5); push(8'd7); push(8'd9);
      wait_drain(50);
      check("frame_cnt_t1", frame_cnt, 1);

      // Two samples never start a frame; the third starts it one cycle later.
      push(8'd11); push(8'd13);
      repeat (20) @(negedge clk);
      check("partial_busy", busy, 0);
      check("partial_x_valid", x_valid, 0);
      @(posedge clk);
      #1;
      push(8'd15);
      @(negedge clk);
      check("latency_not_yet", x_valid, 0);
      @(negedge clk);
      check("latency_start", frame_start, 1);
      wait_drain(50);
      check("frame_cnt_t2", frame_cnt, 2);

      // Back-to-back burst: backpressure and minimum frame period.
      start_q.delete();
      bp_seen = 1'b0;
      for (int i = 0; i < 4 * FL; i++) push(DW'(8'h40 + i));
      wait_drain(300);
      check("burst_frames", start_q.size(), 4);
      for (int i = 1; i < 4 && i < start_q.size(); i++)
         check("burst_period", start_q[i] - start_q[i-1], FL + NT + 1);
      check("burst_s_ready_dropped", bp_seen, 1);
      check("frame_cnt_t3", frame_cnt, 6);

      // Random data and gaps over ten frames (pointer wrap, push during pop).
      for (int i = 0; i < 10 * FL; i++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         push(DW'($urandom));
      end
      wait_drain(500);
      check("frame_cnt_t4", frame_cnt, 16);

      // Reset in the second flush cycle with a leftover sample buffered.
      push(8'd20); push(8'd21); push(8'd22); push(8'd23);
      begin
         int n = 0;
         while (!frame_start && n < 50) begin
            @(negedge clk);
            n++;
         end
         check("t5_frame_started", frame_start, 1);
      end
      repeat (SLOTS - 1) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_x_valid", x_valid, 0);
      check("abort_x_out", x_out, 0);
      check("abort_busy", busy, 0);
      check("abort_frame_done", frame_done, 0);
      check("abort_frame_cnt", frame_cnt, 0);
      check("abort_s_ready", s_if.s_ready, 1);
      exp_q.delete();
      pend_q.delete();
      #20;
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      push(8'd31); push(8'd32);
      repeat (5) @(negedge clk);
      check("abort_fifo_emptied", busy, 0);
      @(posedge clk);
      #1;
      push(8'd33);
      wait_drain(50);
      check("frame_cnt_t5", frame_cnt, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
